// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac result accumulator.
//   - default width constants for the mac datapath and accumulator
//   - window FSM state encoding
package mac_pkg;

  localparam int unsigned MAC_DATA_W = 32;
  localparam int unsigned MAC_ACC_W  = 40;
  localparam int unsigned MAC_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: window-length, input beat and output result handshakes
// of mac_accumulator.
//   len       : window length in beats (0 means 2^LEN_W)
//   in_valid  / in_ready  / in_data           : input beat handshake
//   out_valid / out_ready / out_sum / out_ovf : held result handshake
//   busy      : a window is open
// Modports: slave = the accumulator, master = the producer/consumer side.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned LEN_W  = MAC_LEN_W
) ();

  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              busy;

  modport slave (
    input  len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/mac_accumulator_acc_add_sat.sv
// acc_add_sat: combinational ACC_W-bit add of a zero-extended DATA_W operand.
//   acc_i   : running sum
//   data_i  : new beat, unsigned
//   sum_o   : result (wrapped, or clamped to all ones on carry)
//   carry_o : carry out of bit ACC_W-1
// Build option: MAC_ACC_SATURATE_EN defined selects clamping on carry.
module acc_add_sat #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  always_comb begin
    full    = {1'b0, acc_i} + (ACC_W+1)'(data_i);
    carry_o = full[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
    sum_o   = carry_o ? '1 : full[ACC_W-1:0];
`else
    sum_o   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmable window of mac results and holds the
// wide sum until the consumer takes it.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mac_accumulator_if.slave (len, input beat handshake, held result
//         handshake with sticky overflow, busy)
// Build option: MAC_ACC_SATURATE_EN (see acc_add_sat) clamps the sum on
// overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned LEN_W  = MAC_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_accumulator_if.slave     bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [LEN_W:0]   cnt_q,   cnt_d;
  logic [LEN_W:0]   len_q,   len_d;
  logic             ovf_q,   ovf_d;

  logic             accept;
  logic [LEN_W:0]   len_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  acc_add_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .data_i  (bus.in_data),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // len of 0 encodes a full 2^LEN_W window, hence the extra count bit.
  always_comb begin
    len_ext = {1'b0, bus.len};
    if (bus.len == '0) begin
      len_ext = {1'b1, {LEN_W{1'b0}}};
    end
  end

  always_comb begin
    bus.in_ready  = ((state_q == ST_IDLE) || (state_q == ST_ACC)) && !rst;
    bus.out_valid = (state_q == ST_HOLD);
    bus.out_sum   = acc_q;
    bus.out_ovf   = ovf_q;
    bus.busy      = (state_q == ST_ACC) || (state_q == ST_HOLD);
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = len_ext;
          acc_d   = ACC_W'(bus.in_data);
          cnt_d   = (LEN_W+1)'(1);
          ovf_d   = 1'b0;
          state_d = (len_ext == (LEN_W+1)'(1)) ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q + (LEN_W+1)'(1);
          if (cnt_d == len_q) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed bench for mac_accumulator. A 40-bit instance
// covers the window behaviour; a 34-bit instance covers accumulator overflow
// (expectation depends on MAC_ACC_SATURATE_EN).
module tb_mac_accumulator;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mac_accumulator_if #(.DATA_W(32), .ACC_W(40), .LEN_W(8)) bus   ();
  mac_accumulator_if #(.DATA_W(32), .ACC_W(34), .LEN_W(8)) bus34 ();

  mac_accumulator #(.DATA_W(32), .ACC_W(40), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mac_accumulator #(.DATA_W(32), .ACC_W(34), .LEN_W(8)) dut34 (
    .clk (clk),
    .rst (rst),
    .bus (bus34)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_sum !== 40'd0 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h ovf=%b, need 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_ovf);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b need 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.len = 8'd4;
    beat(32'd1);
    beat(32'd2);
    beat(32'd3);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pre: out_valid=%b busy=%b need 0 1", bus.out_valid, bus.busy);
    end
    beat(32'd4);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd10 || bus.out_ovf !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: valid=%b sum=%0d ovf=%b in_ready=%b need 1 10 0 0",
               bus.out_valid, bus.out_sum, bus.out_ovf, bus.in_ready);
    end
    release_result();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_release: valid=%b busy=%b in_ready=%b need 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_backpressure_gaps();
    bus.len = 8'd3;
    beat(32'd7);
    tick();
    tick();
    beat(32'd0);
    tick();
    tick();
    vectors++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_state: busy=%b valid=%b need 1 0", bus.busy, bus.out_valid);
    end
    beat(32'd9);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd16 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid=%b sum=%0d in_ready=%b need 1 16 0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready);
      end
      tick();
    end
    release_result();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_reentry: in_ready=%b valid=%b busy=%b need 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_len_one();
    bus.len = 8'd1;
    beat(32'd42);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd42) begin
      miscompares++;
      $display("FAIL len_one: valid=%b sum=%0d need 1 42", bus.out_valid, bus.out_sum);
    end
    release_result();
  endtask

  task automatic test_full_length();
    bus.len = 8'd0;
    for (int i = 0; i < 255; i++) begin
      beat(32'hFFFF_FFFF);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pre: valid=%b need 0 after 255 beats", bus.out_valid);
    end
    beat(32'hFFFF_FFFF);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'hFF_FFFF_FF00 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_result: valid=%b sum=%h ovf=%b need 1 ffffffff00 0",
               bus.out_valid, bus.out_sum, bus.out_ovf);
    end
    release_result();
  endtask

  task automatic test_overflow();
    logic [33:0] exp_sum;
`ifdef MAC_ACC_SATURATE_EN
    exp_sum = 34'h3_FFFF_FFFF;
`else
    exp_sum = 34'h3_FFFF_FFF8;
`endif
    bus34.len = 8'd8;
    for (int i = 0; i < 8; i++) begin
      bus34.in_valid = 1'b1;
      bus34.in_data  = 32'hFFFF_FFFF;
      tick();
    end
    bus34.in_valid = 1'b0;
    bus34.in_data  = '0;
    vectors++;
    if (bus34.out_valid !== 1'b1 || bus34.out_sum !== exp_sum || bus34.out_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: valid=%b sum=%h ovf=%b need 1 %h 1",
               bus34.out_valid, bus34.out_sum, bus34.out_ovf, exp_sum);
    end
    bus34.out_ready = 1'b1;
    tick();
    bus34.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    bus.len = 8'd4;
    beat(32'd100);
    beat(32'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_sum !== 40'd0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b sum=%0d need 0 0", bus.busy, bus.out_sum);
    end
    beat(32'd5);
    beat(32'd5);
    beat(32'd5);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_result: valid=%b need 0", bus.out_valid);
    end
    beat(32'd5);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd20) begin
      miscompares++;
      $display("FAIL abort_result: valid=%b sum=%0d need 1 20", bus.out_valid, bus.out_sum);
    end
    release_result();
  endtask

  task automatic test_len_latch();
    bus.len = 8'd2;
    beat(32'd3);
    bus.len = 8'd5;
    beat(32'd4);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd7) begin
      miscompares++;
      $display("FAIL len_latch: valid=%b sum=%0d need 1 7", bus.out_valid, bus.out_sum);
    end
    release_result();
  endtask

  task automatic test_out_ready_idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL out_ready_idle: valid=%b busy=%b in_ready=%b need 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.len         = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    bus34.len       = '0;
    bus34.in_valid  = 1'b0;
    bus34.in_data   = '0;
    bus34.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure_gaps();
    test_len_one();
    test_full_length();
    test_overflow();
    test_reset_mid_window();
    test_len_latch();
    test_out_ready_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Streaming window accumulator sitting directly downstream of the approximate `mac` datapath. It consumes the 32-bit `R` results one per cycle over a valid/ready handshake and sums a programmable number of them (a dot-product window). It presents the wide sum on a held output register with its own valid/ready handshake and a sticky overflow flag.

## Interface
Parameters:
- `DATA_W`, 32: width of incoming `mac` result (unsigned).
- `ACC_W`, 40: accumulator and output width; must be ≥ `DATA_W`.
- `LEN_W`, 8: width of the window-length field.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `len`, in, `LEN_W`: window length in beats; sampled on the first beat of each window. Value 0 means 2^`LEN_W` beats.
- `in_valid`, in, 1: `in_data` holds a valid `mac` result.
- `in_ready`, out, 1: block accepts a beat this cycle.
- `in_data`, in, `DATA_W`: `R` output of `mac`, unsigned.
- `out_valid`, out, 1: `out_sum` and `out_ovf` are valid and held.
- `out_ready`, in, 1: consumer takes the result.
- `out_sum`, out, `ACC_W`: window sum.
- `out_ovf`, out, 1: an add in this window overflowed `ACC_W`.
- `busy`, out, 1: a window is open (at least one beat accepted, result not yet produced).

## Operation
- A beat is accepted when `in_valid & in_ready`. Idle cycles with `in_valid` low are allowed anywhere and do not affect the sum.
- States:
  - IDLE: `in_ready`=1. The first accepted beat latches `len` into `len_q`, loads `acc <= in_data` (zero-extended), sets `cnt <= 1` and `ovf <= 0`, then moves to ACC. If `len_q` equals 1, it moves to HOLD instead.
  - ACC: `in_ready`=1. Each accepted beat does `acc <= acc + in_data` and `cnt <= cnt + 1`. The beat that makes `cnt` equal `len_q` moves the block to HOLD.
  - HOLD: `in_ready`=0 and `out_valid`=1. `out_sum` = `acc`, `out_ovf` = `ovf`, both stable. On `out_ready`, the block moves to IDLE.
- The count comparison uses `LEN_W+1` bits, so `len`=0 gives 2^`LEN_W` beats.
- Arithmetic is unsigned, width `ACC_W+1`. Bit `ACC_W` is the carry; a carry sets the sticky `ovf`.
- `len` changes mid-window are ignored; only `len_q` is used.
- `busy` = (state == ACC) or (state == HOLD).

## Timing
- Reset values: `in_ready`=0 during the cycle `rst` is high; all of `out_valid`, `out_sum`, `out_ovf`, `busy`, `acc`, `cnt`, `ovf` = 0. State is IDLE. `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: the last beat is accepted at edge t, and `out_valid`=1 from cycle t+1.
- Throughput: 1 beat/cycle within a window. There is at least one non-accepting cycle (HOLD) between windows. IDLE accepts in the cycle after `out_ready` is seen in HOLD.
- `out_ready` high outside HOLD is ignored.
- Reset during ACC or HOLD discards the partial or held result. No output is produced for that window.
- Backpressure: HOLD persists indefinitely while `out_ready` is low, and the outputs do not change.

## Configuration
- `MAC_ACC_SATURATE_EN` defined: on a carry out, `acc` is clamped to all ones (2^`ACC_W`−1) and stays there for the rest of the window. `ovf` is set.
- Not defined: the sum wraps modulo 2^`ACC_W`. `ovf` is still set and sticky.

## Structure
- Shared package `mac_pkg` holds:
  - the state enum (IDLE, ACC, HOLD);
  - default constants `MAC_DATA_W`=32, `MAC_ACC_W`=40, `MAC_LEN_W`=8.
- One sub-module, `acc_add_sat`:
  - combinational `ACC_W`-bit add of the zero-extended input, with a carry output;
  - clamping only when `MAC_ACC_SATURATE_EN` is defined.
- The FSM, counter and output register live in `mac_accumulator`.

## Test plan
- Basic window: `len`=4, beats 1,2,3,4 back-to-back → `out_valid` the cycle after the 4th beat, `out_sum`=10, `out_ovf`=0, `in_ready`=0 while held.
- Backpressure and gaps:
  - `len`=3, beats 7,0,9 with `in_valid` low for 2 cycles between them, `out_ready` low 5 cycles → `out_sum`=16, held stable for 5 cycles;
  - IDLE is re-entered the cycle after `out_ready`=1.
- Full-length window: `len`=0, 256 beats of 0xFFFFFFFF → `out_sum`=0xFFFFFFFF00, `out_ovf`=0.
- Overflow: `ACC_W`=34, `len`=8, eight beats of 0xFFFFFFFF →
  - with `MAC_ACC_SATURATE_EN`: `out_sum`=0x3FFFFFFFF;
  - without: `out_sum`=0x3FFFFFFF8;
  - `out_ovf`=1 in both cases.
- Reset mid-window: `len`=4, beats 100,200, then `rst` for 1 cycle, then beats 5,5,5,5 → single result `out_sum`=20, with no result for the aborted window.
- Length latch: `len`=2 at the first beat, changed to 5 after it, beats 3,4 → result 7 after 2 beats.
